// File: rtl/key_pkg.sv
// Shared FSM state encodings and the counter-width helper for the key debouncer.
// Latency: none, types and constant functions only.
// Backpressure: not applicable.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  // Bits needed to represent the values 0..v-1, never fewer than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms strobe shared by every key FSM.
// Latency: tick is high for exactly one cycle out of every CLKS_PER_MS.
// Backpressure: none, the strobe is free-running.
module ms_tick_gen
  import key_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int            TW   = clog2(CLKS_PER_MS);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_MS - 1);

  logic [TW-1:0] cnt;

  // Count 0..CLKS_PER_MS-1 and wrap.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_debouncer.sv
// Synchronises and debounces active-low keys; emits level, press/auto-repeat and release pulses.
// Latency: 2 sync cycles + (DEBOUNCE_MS-1..DEBOUNCE_MS) ms + 1 output register per edge.
// Backpressure: none; pulses are one-cycle strobes the consumer must take as they come.
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int CLKS_PER_MS     = 50000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // The same counter times both debounce and repeat delay, so it must hold the larger.
  localparam int CNT_MAX = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int CW      = clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_DELAY_MS - 1);
  localparam logic [CW-1:0] REP_RELOAD = CW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

  if (DEBOUNCE_MS < 1) begin : g_bad_debounce
    $error("key_debouncer: DEBOUNCE_MS must be >= 1");
  end
  if (REPEAT_RATE_MS > REPEAT_DELAY_MS) begin : g_bad_repeat
    $error("key_debouncer: REPEAT_RATE_MS must not exceed REPEAT_DELAY_MS");
  end
  if (REPEAT_RATE_MS < 1) begin : g_bad_rate
    $error("key_debouncer: REPEAT_RATE_MS must be >= 1");
  end
  if (CLKS_PER_MS < 2) begin : g_bad_clks
    $error("key_debouncer: CLKS_PER_MS must be >= 2");
  end

  logic tick;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .tick    (tick)
  );

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          key_s;
    key_state_t    state;
    logic [CW-1:0] cnt;
    logic          down_q;
    logic          press_q;
    logic          rel_q;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_n[k];
        sync2 <= sync1;
      end
    end

    assign key_s = ~sync2;

    // Debounce/auto-repeat FSM: a new level is accepted only after DEBOUNCE_MS ticks stable.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        down_q  <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          IDLE: begin
            if (key_s) begin
              cnt   <= '0;
              state <= PRESS_PEND;
            end
          end
          PRESS_PEND: begin
            if (!key_s) begin
              state <= IDLE;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                state   <= HELD;
                cnt     <= '0;
                press_q <= 1'b1;
                down_q  <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          HELD: begin
            if (!key_s) begin
              cnt   <= '0;
              state <= RELEASE_PEND;
            end else if (tick) begin
              // Reloading below the delay makes later repeats come every REPEAT_RATE_MS.
              if (cnt == REP_LAST) begin
                press_q <= 1'b1;
                cnt     <= REP_RELOAD;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          RELEASE_PEND: begin
            if (key_s) begin
              // Bounce while held: no pulse, and the repeat delay starts over.
              cnt   <= '0;
              state <= HELD;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                state  <= IDLE;
                cnt    <= '0;
                down_q <= 1'b0;
                rel_q  <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end

    assign key_down[k]    = down_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = rel_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus randomized key activity vs a tick-counting model.
// Latency: checks every cycle, 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_key_debouncer;

  localparam int NK  = 4;
  localparam int CPM = 4;
  localparam int DEB = 3;
  localparam int RD  = 10;
  localparam int RR  = 5;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [NK-1:0] key_n    = '1;
  logic [NK-1:0] key_down;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  key_debouncer #(
    .NUM_KEYS       (NK),
    .CLKS_PER_MS    (CPM),
    .DEBOUNCE_MS    (DEB),
    .REPEAT_DELAY_MS(RD),
    .REPEAT_RATE_MS (RR)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_n      (key_n),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- behavioural model ----------------
  // Each key: a level must be seen on two consecutive sampled cycles across DEB ms ticks
  // to be accepted; while held, pulses occur at RD, RD+RR, RD+2RR ... held ticks.
  bit [NK-1:0] h1, h2, ksp, m_down, m_press, m_rel;
  int          run  [NK];
  int          held [NK];
  int          n_edge;

  task automatic model_reset();
    h1 = '1; h2 = '1; ksp = '0;
    m_down = '0; m_press = '0; m_rel = '0;
    n_edge = 0;
    for (int k = 0; k < NK; k++) begin
      run[k]  = 0;
      held[k] = 0;
    end
  endtask

  task automatic model_step();
    bit [NK-1:0] ks;
    bit          tck;
    bit          od;
    n_edge++;
    tck     = ((n_edge % CPM) == 0);
    ks      = ~h2;
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NK; k++) begin
      od = m_down[k];
      if (ks[k] == od) begin
        run[k] = 0;
      end else if (tck && ks[k] == ksp[k]) begin
        run[k]++;
        if (run[k] == DEB) begin
          run[k]    = 0;
          m_down[k] = ~od;
          if (!od) m_press[k] = 1'b1;
          else     m_rel[k]   = 1'b1;
        end
      end
      if (od && ks[k] && ksp[k]) begin
        if (tck) begin
          held[k]++;
          if (held[k] >= RD && ((held[k] - RD) % RR) == 0) m_press[k] = 1'b1;
        end
      end else begin
        held[k] = 0;
      end
    end
    ksp = ks;
    h2  = h1;
    h1  = key_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK_50 or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- per-cycle compare and event log ----------------
  int            press_t [NK][$];
  int            rel_t   [NK][$];
  int            fall_t  [NK];
  logic [NK-1:0] prev_down = '0;

  initial begin
    for (int k = 0; k < NK; k++) fall_t[k] = -1;
    forever begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
      check_vec("key_down",    key_down,    m_down);
      check_vec("key_press",   key_press,   m_press);
      check_vec("key_release", key_release, m_rel);
      check_vec("press_and_release", key_press & key_release, '0);
      check_vec("press_without_down", key_press & ~key_down, '0);
      for (int k = 0; k < NK; k++) begin
        if (key_press[k])   press_t[k].push_back(cyc);
        if (key_release[k]) rel_t[k].push_back(cyc);
        if (prev_down[k] && !key_down[k]) fall_t[k] = cyc;
      end
      prev_down = key_down;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < NK; k++) begin
      press_t[k].delete();
      rel_t[k].delete();
    end
  endtask

  function automatic int total_events();
    int s;
    s = 0;
    for (int k = 0; k < NK; k++) s += press_t[k].size() + rel_t[k].size();
    return s;
  endfunction

  // ---------------- stimulus ----------------
  int t0;
  int tr;

  initial begin
    // 1. reset with keys idle, then 200 quiet cycles
    reset = 1'b1;
    key_n = '1;
    wait_cyc(3);
    check_vec("t1 reset key_down",    key_down,    '0);
    check_vec("t1 reset key_press",   key_press,   '0);
    check_vec("t1 reset key_release", key_release, '0);
    reset = 1'b0;
    clear_logs();
    wait_cyc(200);
    check_int("t1 idle pulses", total_events(), 0);

    // 2. clean 14-cycle press on key 1
    clear_logs();
    t0 = cyc;
    key_n[1] = 1'b0;
    wait_cyc(14);
    key_n[1] = 1'b1;
    wait_cyc(40);
    check_int("t2 press count", press_t[1].size(), 1);
    check_rng("t2 press latency", (press_t[1].size() > 0) ? press_t[1][0] - t0 : -1, 10, 17);
    check_int("t2 release count", rel_t[1].size(), 1);
    check_int("t2 down until release", fall_t[1], (rel_t[1].size() > 0) ? rel_t[1][0] : -1);

    // 3. bouncing key 0, then settled low
    clear_logs();
    for (int s = 0; s < 10; s++) begin
      key_n[0] = (s % 2 == 1);
      wait_cyc(3);
    end
    key_n[0] = 1'b0;
    check_int("t3 no press while bouncing", press_t[0].size(), 0);
    wait_cyc(25);
    check_int("t3 one press after settle", press_t[0].size(), 1);
    key_n[0] = 1'b1;
    wait_cyc(40);
    check_int("t3 one release", rel_t[0].size(), 1);

    // 4. key 2 held 120 cycles: auto-repeat at +40 then every 20
    clear_logs();
    t0 = cyc;
    key_n[2] = 1'b0;
    wait_cyc(120);
    tr = cyc;
    key_n[2] = 1'b1;
    wait_cyc(40);
    check_int("t4 press count", press_t[2].size(), 5);
    check_rng("t4 first press latency", (press_t[2].size() > 0) ? press_t[2][0] - t0 : -1, 10, 17);
    for (int i = 1; i < press_t[2].size(); i++)
      check_int("t4 repeat gap", press_t[2][i] - press_t[2][i-1], (i == 1) ? 40 : 20);
    check_rng("t4 last press vs release",
              (press_t[2].size() > 0) ? press_t[2][press_t[2].size()-1] - tr : 999, -1000, 2);

    // 5. keys 0 and 3 fall together
    clear_logs();
    key_n[0] = 1'b0;
    key_n[3] = 1'b0;
    wait_cyc(20);
    check_int("t5 key0 press count", press_t[0].size(), 1);
    check_int("t5 key3 press count", press_t[3].size(), 1);
    check_int("t5 same cycle",
              (press_t[0].size() > 0) ? press_t[0][0] : -1,
              (press_t[3].size() > 0) ? press_t[3][0] : -2);
    key_n[0] = 1'b1;
    key_n[3] = 1'b1;
    wait_cyc(40);

    // 6. reset while key 1 is held
    clear_logs();
    key_n[1] = 1'b0;
    wait_cyc(25);
    check_vec("t6 held before reset", key_down, 4'b0010);
    reset = 1'b1;
    #1;
    check_vec("t6 async clear key_down",  key_down,  '0);
    check_vec("t6 async clear key_press", key_press, '0);
    wait_cyc(5);
    clear_logs();
    reset = 1'b0;
    wait_cyc(25);
    check_int("t6 new press after reset", press_t[1].size(), 1);
    check_int("t6 no release", rel_t[1].size(), 0);
    key_n[1] = 1'b1;
    wait_cyc(40);
    check_int("t6 release after key up", rel_t[1].size(), 1);

    // randomized activity: mixed bounce lengths, long holds, occasional reset
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        wait_cyc($urandom_range(1, 3));
        reset = 1'b0;
      end
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 1) == 1) key_n[k] = ~key_n[k];
      if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 4));
      else                           wait_cyc($urandom_range(1, 60));
    end
    key_n = '1;
    wait_cyc(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
